// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads program memory over a req/ack handshake,
// latches the returned word in the IR and offers it to decode with valid/ready.
// A jump redirects the PC and flushes whatever is in flight or held.
module instruction_fetch_unit #(
   parameter int PC_WIDTH    = 4,
   parameter int INSTR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   mem_req,
   output logic [PC_WIDTH-1:0]    mem_addr,
   input  logic                   mem_ack,
   input  logic [INSTR_WIDTH-1:0] mem_rdata,
   input  logic                   jump_valid,
   input  logic [PC_WIDTH-1:0]    jump_target,
   input  logic                   halt,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic                   halted
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;

   // Next-state, PC and IR selection; a jump outranks ack, ready and halt
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      if (jump_valid) begin
         pc_d    = jump_target;
         state_d = FETCH;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (mem_ack) begin
                  ir_d    = mem_rdata;
                  pc_d    = pc_q + PC_WIDTH'(1);
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  state_d = halt ? HALTED : FETCH;
               end
            end
            HALTED: begin
               if (!halt) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // State, PC and IR registers; reset wins over any late ack
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Outputs decode straight from state; req is held off while reset is asserted
   always_comb begin
      mem_req     = (state_q == FETCH) && !reset;
      mem_addr    = pc_q;
      instr_out   = ir_q;
      instr_valid = (state_q == HOLD);
      pc_out      = pc_q;
      halted      = (state_q == HALTED);
   end

endmodule
